traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Two-way (North-South / East-West) traffic-light controller with a pedestrian walk phase.
- Consumes the slow square-wave output of the frequency divider as a time base: synchronises it into the fast clock domain and converts each rising edge into a one-cycle tick.
- Every phase dwell is counted in ticks.
- Sits directly downstream of the divider; its outputs drive the board LEDs.

Parameters:
- GREEN_TICKS, 8, green dwell per direction, in ticks (>=1)
- YELLOW_TICKS, 3, yellow dwell, in ticks (>=1)
- ALLRED_TICKS, 1, all-red clearance dwell, in ticks (>=1)
- WALK_TICKS, 5, pedestrian walk dwell, in ticks (>=1)
- CNT_W, 8, dwell counter width; every *_TICKS value must be <= 2^CNT_W

Ports:
- clock_in  input  1  fast system clock; all flops on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- slow_clk  input  1  divided clock level from the divider; asynchronous to clock_in logic, treated as data
- enable  input  1  1 = run; 0 = freeze state and dwell count
- ped_req  input  1  pedestrian button, synchronous level
- ns_light  output  3  {red,yellow,green} for North-South
- ew_light  output  3  {red,yellow,green} for East-West
- walk  output  1  pedestrian walk lamp
- ped_pending  output  1  latched pedestrian request
- tick  output  1  one-cycle time-base pulse (debug)
- state_out  output  3  current state code

Behaviour:
- Time base:
  - slow_clk passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3 (combinational).
  - tick is high for exactly one clock_in cycle, starting after the 2nd clock_in rising edge following a slow_clk rise.
  - Falling edges of slow_clk produce nothing.
- Reset:
  - s1/s2/s3 = 0, state = ALL_RED_2 (5), dwell count = 0, ped_pending = 0.
  - ns_light = ew_light = 3'b100, walk = 0.
  - If slow_clk is high at reset release, one tick is produced; this is required behaviour.
- State codes:
  - NS_GREEN = 0, NS_YELLOW = 1, ALL_RED_1 = 2, EW_GREEN = 3
  - EW_YELLOW = 4, ALL_RED_2 = 5, WALK_1 = 6, WALK_2 = 7
- Dwell rule:
  - The counter clears to 0 on state entry.
  - On a clock edge with tick & enable: if count == DUR-1 the state transitions and count is cleared; otherwise count increments.
  - Each state therefore lasts exactly DUR ticks after entry.
- Transitions (taken on dwell expiry only):
  - NS_GREEN -> NS_YELLOW -> ALL_RED_1
  - ALL_RED_1 -> WALK_1 if ped_pending, else EW_GREEN; WALK_1 -> EW_GREEN
  - EW_GREEN -> EW_YELLOW -> ALL_RED_2
  - ALL_RED_2 -> WALK_2 if ped_pending, else NS_GREEN; WALK_2 -> NS_GREEN
- Outputs are registered Moore outputs, updated on the same edge as state:
  - Green state: that direction 001, the other 100.
  - Yellow state: that direction 010, the other 100.
  - ALL_RED and WALK states: both 100.
  - walk = 1 only in WALK_1/WALK_2.
  - state_out = state register.
  - Two directions are never simultaneously non-red.
- Pedestrian latch:
  - Sets on any clock with ped_req = 1.
  - Clears on the edge that enters WALK_1/WALK_2; clear wins over a simultaneous set.
  - ped_req while walk = 1 is ignored.
  - A request raised during ALL_RED_x before its expiry edge is served in that same clearance.
- enable = 0:
  - Ticks are ignored; state, count and outputs hold; the synchroniser keeps running.
  - The ped latch keeps capturing requests.
  - Resuming continues from the held count.
- Asynchronous reset mid-phase forces the reset values immediately, regardless of clock.
- Full cycle without pedestrians: 2*(GREEN+YELLOW+ALLRED) = 24 ticks at defaults.

Test Plan:
- Reset with slow_clk = 0, then toggle slow_clk with period 20 clock_in cycles, enable = 1, no ped_req:
  - States 5 -> 0 after 1 tick, 1 after 8 more ticks, 2 after 3, 3 after 1, 4 after 8, 5 after 3.
  - Lights match the encodings at every step.
- Tick check: slow_clk rises at cycle T -> tick high only during the cycle after the 2nd edge following T, width 1; a slow_clk fall produces no tick.
- ped_req pulsed 1 cycle during NS_GREEN:
  - ped_pending = 1; after ALL_RED_1 expiry state = 6, walk = 1 for 5 ticks, ped_pending = 0; then EW_GREEN.
  - ped_req held high across the whole walk is not re-latched.
- enable dropped for 10 ticks mid EW_GREEN at count 4: state and lights frozen; after re-enable, EW_YELLOW is entered exactly 4 ticks later.
- reset_n asserted mid NS_YELLOW, asynchronously between clock edges: outputs go to 100/100, walk = 0, state_out = 5 with no clock edge.
- reset_n released with slow_clk = 1: one tick occurs and moves state 5 -> 0 with ALLRED_TICKS = 1.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-way traffic light controller with pedestrian walk phase
// Time base is the divided slow_clk, synchronised and edge-detected into one-cycle ticks.
module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 5,
  parameter int CNT_W        = 8
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       slow_clk,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic       tick,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    WALK_1    = 3'd6,
    WALK_2    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_TICKS - 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  logic             s1_q, s2_q, s3_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_m1;
  logic             ped_q, ped_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             walk_q, walk_d;
  logic             enter_walk;

  assign tick = s2_q & ~s3_q;

  always_comb begin
    dur_m1 = ALLRED_M1;
    case (state_q)
      NS_GREEN, EW_GREEN:   dur_m1 = GREEN_M1;
      NS_YELLOW, EW_YELLOW: dur_m1 = YELLOW_M1;
      WALK_1, WALK_2:       dur_m1 = WALK_M1;
      default:              dur_m1 = ALLRED_M1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick && enable) begin
      if (cnt_q == dur_m1) begin
        cnt_d = '0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_1;
          ALL_RED_1: state_d = ped_q ? WALK_1 : EW_GREEN;
          WALK_1:    state_d = EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_2;
          ALL_RED_2: state_d = ped_q ? WALK_2 : NS_GREEN;
          WALK_2:    state_d = NS_GREEN;
          default:   state_d = ALL_RED_2;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Clearing on walk entry beats a simultaneous press; presses during walk are dropped.
  always_comb begin
    enter_walk = ((state_d == WALK_1) || (state_d == WALK_2)) &&
                 (state_d != state_q);
    ped_d      = enter_walk ? 1'b0 : (ped_q | (ped_req & ~walk_q));
  end

  always_comb begin
    ns_d   = RED;
    ew_d   = RED;
    walk_d = 1'b0;
    case (state_d)
      NS_GREEN:       ns_d   = GREEN;
      NS_YELLOW:      ns_d   = YELLOW;
      EW_GREEN:       ew_d   = GREEN;
      EW_YELLOW:      ew_d   = YELLOW;
      WALK_1, WALK_2: walk_d = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= ALL_RED_2;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      ns_q    <= RED;
      ew_q    <= RED;
      walk_q  <= 1'b0;
    end else begin
      s1_q    <= slow_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       slow_clk;
  logic       enable;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic       tick;
  logic [2:0] state_out;

  int checks = 0;
  int failures = 0;

  traffic_light_fsm dut (
    .clock_in    (clk),
    .reset_n     (reset_n),
    .slow_clk    (slow_clk),
    .enable      (enable),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .tick        (tick),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  // {ns, ew, walk} expected for each state code
  function automatic logic [6:0] exp_lamps(input int s);
    case (s)
      0:       return {3'b001, 3'b100, 1'b0};
      1:       return {3'b010, 3'b100, 1'b0};
      3:       return {3'b100, 3'b001, 1'b0};
      4:       return {3'b100, 3'b010, 1'b0};
      6, 7:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  // One full slow_clk period of 20 clock_in cycles; ends sampled at a falling edge.
  task automatic one_tick();
    @(negedge clk) slow_clk = 1'b1;
    repeat (10) @(negedge clk);
    slow_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; slow_clk = 1'b0; enable = 1'b1; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_out !== 3'd5) begin failures++; $display("FAIL reset_state got=%0d exp=5", state_out); end
    checks++;
    if ({ns_light, ew_light, walk} !== 7'b1001000) begin
      failures++; $display("FAIL reset_lamps got=%b exp=%b", {ns_light, ew_light, walk}, 7'b1001000);
    end
    checks++;
    if ({ped_pending, tick} !== 2'b00) begin failures++; $display("FAIL reset_ped_tick got=%b exp=00", {ped_pending, tick}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tick();
    logic [2:0] seen;
    @(negedge clk) slow_clk = 1'b1;
    @(negedge clk) seen[0] = tick;
    @(negedge clk) seen[1] = tick;
    @(negedge clk) seen[2] = tick;
    checks++;
    if (seen !== 3'b010) begin failures++; $display("FAIL tick_rise_shape got=%b exp=010", seen); end
    checks++;
    if (state_out !== 3'd0) begin failures++; $display("FAIL tick_first_move got=%0d exp=0", state_out); end
    repeat (7) @(negedge clk);
    slow_clk = 1'b0;
    seen = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tick) seen = 3'b111;
    end
    checks++;
    if (seen !== 3'b000) begin failures++; $display("FAIL tick_on_fall got=%b exp=000", seen); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cycle();
    int ph_state[6] = '{0, 1, 2, 3, 4, 5};
    int ph_dur[6]   = '{8, 3, 1, 8, 3, 1};
    int exp_s;
    logic [6:0] exp_l;
    int bad;
    bad = 0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < ph_dur[p]; k++) begin
        one_tick();
        exp_s = (k == ph_dur[p] - 1) ? ph_state[(p + 1) % 6] : ph_state[p];
        exp_l = exp_lamps(exp_s);
        checks++;
        if (state_out !== 3'(exp_s) || {ns_light, ew_light, walk} !== exp_l) begin
          failures++; bad++;
          $display("FAIL cycle_p%0d_k%0d got state=%0d lamps=%b exp state=%0d lamps=%b",
                   p, k, state_out, {ns_light, ew_light, walk}, exp_s, exp_l);
        end
      end
    end
  endtask

  task automatic test_ped_walk1();
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b1) begin failures++; $display("FAIL ped_latch got=%b exp=1", ped_pending); end
    repeat (11) one_tick();
    checks++;
    if (state_out !== 3'd2) begin failures++; $display("FAIL ped_allred1 got=%0d exp=2", state_out); end
    ped_req = 1'b1;
    one_tick();
    checks++;
    if (state_out !== 3'd6 || walk !== 1'b1 || {ns_light, ew_light} !== 6'b100100) begin
      failures++; $display("FAIL walk1_entry got state=%0d walk=%b lamps=%b exp 6 1 100100",
                           state_out, walk, {ns_light, ew_light});
    end
    checks++;
    if (ped_pending !== 1'b0) begin failures++; $display("FAIL walk1_clear got=%b exp=0", ped_pending); end
    repeat (4) one_tick();
    checks++;
    if (state_out !== 3'd6 || walk !== 1'b1 || ped_pending !== 1'b0) begin
      failures++; $display("FAIL walk1_hold got state=%0d walk=%b ped=%b exp 6 1 0", state_out, walk, ped_pending);
    end
    ped_req = 1'b0;
    one_tick();
    checks++;
    if (state_out !== 3'd3 || {ns_light, ew_light, walk} !== 7'b1000010 || ped_pending !== 1'b0) begin
      failures++; $display("FAIL walk1_exit got state=%0d lamps=%b ped=%b exp 3 1000010 0",
                           state_out, {ns_light, ew_light, walk}, ped_pending);
    end
  endtask

  task automatic test_enable();
    int bad;
    repeat (4) one_tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      one_tick();
      if (i == 3) begin
        @(negedge clk) ped_req = 1'b1;
        @(negedge clk) ped_req = 1'b0;
      end
      if (state_out !== 3'd3 || ew_light !== 3'b001 || ns_light !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL enable_freeze got bad_steps=%0d exp=0", bad); end
    checks++;
    if (ped_pending !== 1'b1) begin failures++; $display("FAIL enable_ped_capture got=%b exp=1", ped_pending); end
    enable = 1'b1;
    repeat (3) one_tick();
    checks++;
    if (state_out !== 3'd3) begin failures++; $display("FAIL resume_hold got=%0d exp=3", state_out); end
    one_tick();
    checks++;
    if (state_out !== 3'd4 || ew_light !== 3'b010) begin
      failures++; $display("FAIL resume_yellow got state=%0d ew=%b exp 4 010", state_out, ew_light);
    end
  endtask

  task automatic test_walk2();
    repeat (3) one_tick();
    checks++;
    if (state_out !== 3'd5) begin failures++; $display("FAIL walk2_allred2 got=%0d exp=5", state_out); end
    one_tick();
    checks++;
    if (state_out !== 3'd7 || walk !== 1'b1 || ped_pending !== 1'b0) begin
      failures++; $display("FAIL walk2_entry got state=%0d walk=%b ped=%b exp 7 1 0", state_out, walk, ped_pending);
    end
    repeat (5) one_tick();
    checks++;
    if (state_out !== 3'd0 || {ns_light, ew_light, walk} !== 7'b0011000) begin
      failures++; $display("FAIL walk2_exit got state=%0d lamps=%b exp 0 0011000", state_out, {ns_light, ew_light, walk});
    end
  endtask

  task automatic test_async_reset();
    repeat (8) one_tick();
    checks++;
    if (state_out !== 3'd1) begin failures++; $display("FAIL pre_reset_yellow got=%0d exp=1", state_out); end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (state_out !== 3'd5 || {ns_light, ew_light, walk} !== 7'b1001000) begin
      failures++; $display("FAIL async_reset got state=%0d lamps=%b exp 5 1001000", state_out, {ns_light, ew_light, walk});
    end
  endtask

  task automatic test_release_high();
    logic saw_tick;
    @(negedge clk) slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tick) saw_tick = 1'b1;
    end
    checks++;
    if (saw_tick !== 1'b1) begin failures++; $display("FAIL release_tick got=%b exp=1", saw_tick); end
    checks++;
    if (state_out !== 3'd0 || ns_light !== 3'b001) begin
      failures++; $display("FAIL release_move got state=%0d ns=%b exp 0 001", state_out, ns_light);
    end
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tick();
    test_cycle();
    test_ped_walk1();
    test_enable();
    test_walk2();
    test_async_reset();
    test_release_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
